id_stage: RTL and testbench
===========================

ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 DATA_WIDTH, 32 (package constant), width of operands, PC and immediate.
REQ-002 clk  in  1  pipeline clock, all state on rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 if_valid  in  1  fetch presents instruction.
REQ-005 if_ready  out  1  stage accepts instruction this cycle.
REQ-006 if_instr  in  32  instruction word.
REQ-007 if_pc  in  DATA_WIDTH  instruction address.
REQ-008 rf_addr_rd1 / rf_addr_rd2  out  5  register file read addresses (instr[19:15] / instr[24:20]).
REQ-009 rf_data_rd1 / rf_data_rd2  in  DATA_WIDTH  combinational register file read data.
REQ-010 wb_wr_en, wb_addr[4:0], wb_data[DATA_WIDTH]  in  snooped writeback port driving the register file.
REQ-011 ex_ld_pending  in  1, ex_ld_rd  in  5  load in EX with its destination.
REQ-012 flush  in  1  kill ID contents and current fetch.
REQ-013 id_valid  out  1, id_ready  in  1  ID/EX handshake.
REQ-014 id_pc, id_rs1_val, id_rs2_val, id_imm  out  DATA_WIDTH  registered decode results.
REQ-015 id_rd  out  5, id_opcode  out  7, id_funct3  out  3, id_funct7  out  7, id_illegal  out  1.

Function
REQ-016 Transfer IF->ID SHALL occur when if_valid && if_ready; outputs SHALL be registered, 1-cycle latency.
REQ-017 if_ready SHALL equal !hazard && !flush && (!id_valid || id_ready).
REQ-018 hazard SHALL be ex_ld_pending && ex_ld_rd!=0 && ((uses_rs1 && ex_ld_rd==rs1) || (uses_rs2 && ex_ld_rd==rs2)).
REQ-019 uses_rs1 for opcodes OP, OP-IMM, LOAD, STORE, BRANCH, JALR; uses_rs2 for OP, STORE, BRANCH only.
REQ-020 On hazard with id_valid && id_ready, id_valid SHALL drop next cycle (bubble); with id_ready low, ID contents SHALL hold.
REQ-021 While id_valid && !id_ready, all id_* outputs SHALL stay stable.
REQ-022 When id_ready && !transfer, id_valid SHALL clear next cycle.
REQ-023 flush SHALL clear id_valid next cycle, override a simultaneous transfer, and ignore hazard.
REQ-024 Operand select: rs==0 -> 0; else wb_wr_en && wb_addr==rs -> wb_data (when bypass compiled in); else rf_data.
REQ-025 id_imm SHALL be sign-extended: I (OP-IMM, LOAD, JALR), S, B (bit0=0), U (low 12 = 0), J (bit0=0); other opcodes 0.
REQ-026 id_illegal SHALL be 1 for opcodes outside LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP, or instr[1:0]!=2'b11; illegal instructions still transfer.
REQ-027 id_rd SHALL be forced to 0 for STORE and BRANCH.

Reset
REQ-028 rst_n low SHALL immediately clear id_valid, id_illegal and all id_* data outputs to 0, independent of clk.
REQ-029 Reset mid-stall SHALL discard held instruction; first post-reset cycle id_valid=0.

Configuration
REQ-030 Macro ID_WB_BYPASS_EN defined: REQ-024 writeback bypass active; no extra stall.
REQ-031 Macro undefined: no bypass; hazard additionally SHALL assert when wb_wr_en && wb_addr!=0 matches a used rs, stalling until the write retires.

Verification
REQ-032 Reset: rst_n=0 asynchronously mid-cycle -> id_valid=0, id_rs1_val=0 immediately.
REQ-033 addi x1,x0,-5 (0xFFB00093), id_ready=1 -> next cycle id_valid=1, id_imm=0xFFFFFFFB, id_rd=1, id_rs1_val=0.
REQ-034 Load-use: ex_ld_pending=1, ex_ld_rd=5, instr add x6,x5,x7 -> if_ready=0, id_valid=0 next cycle; ex_ld_pending=0 -> transfer.
REQ-035 Bypass (ID_WB_BYPASS_EN): wb_wr_en=1, wb_addr=3, wb_data=0x1234, rf_data_rd1=0, rs1=3 -> id_rs1_val=0x1234; macro undefined -> one stall, then rf value.
REQ-036 Backpressure: id_ready=0 for 3 cycles with new if_valid -> id_* stable, if_ready=0; flush in cycle 2 -> id_valid=0 next cycle.
REQ-037 Illegal: instr 0x00000000 -> id_illegal=1, id_valid=1, id_imm=0.

Source files
------------

// File: rtl/id_stage_if.sv
// IF->ID and ID->EX handshake bundle for the decode stage.
// Master is the pipeline environment; slave is id_stage.
interface id_stage_if #(
    parameter int W = 32
) ();
    logic          if_valid;
    logic          if_ready;
    logic [31:0]   if_instr;
    logic [W-1:0]  if_pc;
    logic          id_valid;
    logic          id_ready;
    logic [W-1:0]  id_pc;
    logic [W-1:0]  id_rs1_val;
    logic [W-1:0]  id_rs2_val;
    logic [W-1:0]  id_imm;
    logic [4:0]    id_rd;
    logic [6:0]    id_opcode;
    logic [2:0]    id_funct3;
    logic [6:0]    id_funct7;
    logic          id_illegal;

    modport master (
        output if_valid, if_instr, if_pc, id_ready,
        input  if_ready, id_valid, id_pc, id_rs1_val, id_rs2_val,
        input  id_imm, id_rd, id_opcode, id_funct3, id_funct7, id_illegal
    );

    modport slave (
        input  if_valid, if_instr, if_pc, id_ready,
        output if_ready, id_valid, id_pc, id_rs1_val, id_rs2_val,
        output id_imm, id_rd, id_opcode, id_funct3, id_funct7, id_illegal
    );
endinterface

// File: rtl/id_stage.sv
// RV32I decode stage: operand read, immediate build, load-use interlock.
// Define ID_WB_BYPASS_EN to forward the writeback port instead of stalling.
package id_pkg;
    localparam int DATA_WIDTH = 32;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] pc;
        logic [DATA_WIDTH-1:0] rs1_val;
        logic [DATA_WIDTH-1:0] rs2_val;
        logic [DATA_WIDTH-1:0] imm;
        logic [4:0]            rd;
        logic [6:0]            opcode;
        logic [2:0]            funct3;
        logic [6:0]            funct7;
        logic                  illegal;
    } id_ex_t;
endpackage

module id_stage
    import id_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    id_stage_if.slave             io,
    output logic [4:0]            rf_addr_rd1,
    output logic [4:0]            rf_addr_rd2,
    input  logic [DATA_WIDTH-1:0] rf_data_rd1,
    input  logic [DATA_WIDTH-1:0] rf_data_rd2,
    input  logic                  wb_wr_en,
    input  logic [4:0]            wb_addr,
    input  logic [DATA_WIDTH-1:0] wb_data,
    input  logic                  ex_ld_pending,
    input  logic [4:0]            ex_ld_rd,
    input  logic                  flush
);
    logic [31:0]           instr;
    logic [6:0]            opcode;
    logic [4:0]            rs1;
    logic [4:0]            rs2;
    logic                  is_lui;
    logic                  is_auipc;
    logic                  is_jal;
    logic                  is_jalr;
    logic                  is_branch;
    logic                  is_load;
    logic                  is_store;
    logic                  is_opimm;
    logic                  is_op;
    logic                  legal;
    logic                  uses_rs1;
    logic                  uses_rs2;
    logic [DATA_WIDTH-1:0] imm;
    logic [4:0]            rd;
    logic [DATA_WIDTH-1:0] rs1_val;
    logic [DATA_WIDTH-1:0] rs2_val;
    logic                  ld_hit;
    logic                  wb_hit;
    logic                  hazard;
    logic                  if_ready;
    logic                  transfer;
    id_ex_t                data_d;
    id_ex_t                data_q;
    logic                  valid_d;
    logic                  valid_q;

    assign instr       = io.if_instr;
    assign opcode      = instr[6:0];
    assign rs1         = instr[19:15];
    assign rs2         = instr[24:20];
    assign rf_addr_rd1 = rs1;
    assign rf_addr_rd2 = rs2;

    // Full 7-bit match, so instr[1:0] != 2'b11 can never decode as legal.
    assign is_lui    = (opcode == OPC_LUI);
    assign is_auipc  = (opcode == OPC_AUIPC);
    assign is_jal    = (opcode == OPC_JAL);
    assign is_jalr   = (opcode == OPC_JALR);
    assign is_branch = (opcode == OPC_BRANCH);
    assign is_load   = (opcode == OPC_LOAD);
    assign is_store  = (opcode == OPC_STORE);
    assign is_opimm  = (opcode == OPC_OPIMM);
    assign is_op     = (opcode == OPC_OP);

    assign legal = is_lui | is_auipc | is_jal | is_jalr | is_branch
                 | is_load | is_store | is_opimm | is_op;

    assign uses_rs1 = is_op | is_opimm | is_load | is_store
                    | is_branch | is_jalr;
    assign uses_rs2 = is_op | is_store | is_branch;

    assign rd = (is_store || is_branch) ? 5'd0 : instr[11:7];

    always_comb begin
        imm = '0;
        unique case (1'b1)
            is_opimm, is_load, is_jalr:
                imm = {{20{instr[31]}}, instr[31:20]};
            is_store:
                imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            is_branch:
                imm = {{19{instr[31]}}, instr[31], instr[7],
                       instr[30:25], instr[11:8], 1'b0};
            is_lui, is_auipc:
                imm = {instr[31:12], 12'b0};
            is_jal:
                imm = {{11{instr[31]}}, instr[31], instr[19:12],
                       instr[20], instr[30:21], 1'b0};
            default:
                imm = '0;
        endcase
    end

    assign ld_hit = ex_ld_pending && (ex_ld_rd != 5'd0)
                 && ((uses_rs1 && (ex_ld_rd == rs1))
                  || (uses_rs2 && (ex_ld_rd == rs2)));

`ifdef ID_WB_BYPASS_EN
    assign wb_hit  = 1'b0;
    assign rs1_val = (rs1 == 5'd0) ? '0
                   : (wb_wr_en && (wb_addr == rs1)) ? wb_data
                   : rf_data_rd1;
    assign rs2_val = (rs2 == 5'd0) ? '0
                   : (wb_wr_en && (wb_addr == rs2)) ? wb_data
                   : rf_data_rd2;
`else
    // Without forwarding, wait for the write to land in the file.
    assign wb_hit  = wb_wr_en && (wb_addr != 5'd0)
                  && ((uses_rs1 && (wb_addr == rs1))
                   || (uses_rs2 && (wb_addr == rs2)));
    assign rs1_val = (rs1 == 5'd0) ? '0 : rf_data_rd1;
    assign rs2_val = (rs2 == 5'd0) ? '0 : rf_data_rd2;
    logic unused_wb;
    assign unused_wb = ^wb_data;
`endif

    assign hazard      = ld_hit || wb_hit;
    assign if_ready    = !hazard && !flush && (!valid_q || io.id_ready);
    assign io.if_ready = if_ready;
    assign transfer    = io.if_valid && if_ready;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (transfer) begin
            valid_d        = 1'b1;
            data_d.pc      = io.if_pc;
            data_d.rs1_val = rs1_val;
            data_d.rs2_val = rs2_val;
            data_d.imm     = imm;
            data_d.rd      = rd;
            data_d.opcode  = opcode;
            data_d.funct3  = instr[14:12];
            data_d.funct7  = instr[31:25];
            data_d.illegal = !legal;
        end else if (io.id_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign io.id_valid   = valid_q;
    assign io.id_pc      = data_q.pc;
    assign io.id_rs1_val = data_q.rs1_val;
    assign io.id_rs2_val = data_q.rs2_val;
    assign io.id_imm     = data_q.imm;
    assign io.id_rd      = data_q.rd;
    assign io.id_opcode  = data_q.opcode;
    assign io.id_funct3  = data_q.funct3;
    assign io.id_funct7  = data_q.funct7;
    assign io.id_illegal = data_q.illegal;
endmodule

// File: tb/tb_id_stage.sv
// Testbench for id_stage: directed scenarios plus a randomized run
// against a rule-level decode model.
module tb_id_stage;
    import id_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  rf_addr_rd1, rf_addr_rd2;
    logic [31:0] rf_data_rd1, rf_data_rd2;
    logic        wb_wr_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        ex_ld_pending;
    logic [4:0]  ex_ld_rd;
    logic        flush;
    logic [31:0] regs [32];

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    id_stage_if io ();

    id_stage u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .io            (io),
        .rf_addr_rd1   (rf_addr_rd1),
        .rf_addr_rd2   (rf_addr_rd2),
        .rf_data_rd1   (rf_data_rd1),
        .rf_data_rd2   (rf_data_rd2),
        .wb_wr_en      (wb_wr_en),
        .wb_addr       (wb_addr),
        .wb_data       (wb_data),
        .ex_ld_pending (ex_ld_pending),
        .ex_ld_rd      (ex_ld_rd),
        .flush         (flush)
    );

    // The bench plays the register file, x0 deliberately nonzero.
    assign rf_data_rd1 = regs[rf_addr_rd1];
    assign rf_data_rd2 = regs[rf_addr_rd2];
    always @(posedge clk) if (wb_wr_en) regs[wb_addr] <= wb_data;

    function automatic bit is_legal(input logic [6:0] op);
        return op inside {7'h37, 7'h17, 7'h6f, 7'h67, 7'h63,
                          7'h03, 7'h23, 7'h13, 7'h33};
    endfunction

    function automatic bit reads1(input logic [6:0] op);
        return op inside {7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h67};
    endfunction

    function automatic bit reads2(input logic [6:0] op);
        return op inside {7'h33, 7'h23, 7'h63};
    endfunction

    function automatic logic [31:0] ref_imm(input logic [31:0] ins);
        logic [31:0] sx;
        logic [31:0] top;
        sx  = $signed(ins) >>> 20;
        top = $signed(ins) >>> 31;
        case (ins[6:0])
            7'h13, 7'h03, 7'h67: return sx;
            7'h23: return (sx & ~32'h1f) | 32'(ins[11:7]);
            7'h63: return (top << 12) | (32'(ins[7]) << 11)
                        | (32'(ins[30:25]) << 5) | (32'(ins[11:8]) << 1);
            7'h37, 7'h17: return ins & 32'hFFFF_F000;
            7'h6f: return (top << 20) | (32'(ins[19:12]) << 12)
                        | (32'(ins[20]) << 11) | (32'(ins[30:21]) << 1);
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] ref_opnd(input logic [4:0] r);
        if (r == 0) return 32'h0;
`ifdef ID_WB_BYPASS_EN
        if (wb_wr_en && wb_addr == r) return wb_data;
`endif
        return regs[r];
    endfunction

    function automatic bit ref_hazard(input logic [31:0] ins);
        logic [4:0] a, b;
        bit u1, u2, h;
        a  = ins[19:15];
        b  = ins[24:20];
        u1 = reads1(ins[6:0]);
        u2 = reads2(ins[6:0]);
        h  = ex_ld_pending && ex_ld_rd != 0
          && ((u1 && ex_ld_rd == a) || (u2 && ex_ld_rd == b));
`ifndef ID_WB_BYPASS_EN
        h = h || (wb_wr_en && wb_addr != 0
          && ((u1 && wb_addr == a) || (u2 && wb_addr == b)));
`endif
        return h;
    endfunction

    function automatic logic [150:0] ref_pack(input logic [31:0] ins,
                                              input logic [31:0] pc);
        logic [4:0] rd;
        rd = (ins[6:0] == 7'h23 || ins[6:0] == 7'h63) ? 5'd0 : ins[11:7];
        return {pc, ref_opnd(ins[19:15]), ref_opnd(ins[24:20]),
                ref_imm(ins), rd, ins[6:0], ins[14:12], ins[31:25],
                !is_legal(ins[6:0])};
    endfunction

    function automatic logic [150:0] dut_pack();
        return {io.id_pc, io.id_rs1_val, io.id_rs2_val, io.id_imm,
                io.id_rd, io.id_opcode, io.id_funct3, io.id_funct7,
                io.id_illegal};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        io.if_valid   = 1'b0;
        io.if_instr   = 32'h0000_0013;
        io.if_pc      = 32'h0;
        io.id_ready   = 1'b1;
        wb_wr_en      = 1'b0;
        wb_addr       = 5'd0;
        wb_data       = 32'h0;
        ex_ld_pending = 1'b0;
        ex_ld_rd      = 5'd0;
        flush         = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        idle();
        rst_n = 1'b0;
        #2;
        n_chk++;
        if (io.id_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_valid got %b want 0", io.id_valid);
        end
        n_chk++;
        if (dut_pack() !== 151'h0) begin
            n_fail++;
            $display("FAIL reset_data got %h want 0", dut_pack());
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_addi();
        idle();
        regs[0] = 32'hDEAD_BEEF;
        io.if_valid = 1'b1;
        io.if_instr = 32'hFFB0_0093;
        io.if_pc    = 32'h0000_0100;
        #1;
        n_chk++;
        if (io.if_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL addi_if_ready got %b want 1", io.if_ready);
        end
        tick();
        io.if_valid = 1'b0;
        n_chk++;
        if ({io.id_valid, io.id_imm, io.id_rd, io.id_rs1_val, io.id_pc}
            !== {1'b1, 32'hFFFF_FFFB, 5'd1, 32'h0, 32'h100}) begin
            n_fail++;
            $display("FAIL addi got v=%b imm=%h rd=%0d rs1=%h pc=%h want 1 fffffffb 1 0 100",
                     io.id_valid, io.id_imm, io.id_rd, io.id_rs1_val, io.id_pc);
        end
        tick();
        n_chk++;
        if (io.id_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL drain_valid got %b want 0", io.id_valid);
        end
    endtask

    task automatic test_load_use();
        idle();
        regs[5] = 32'h5555_0005;
        regs[7] = 32'h7777_0007;
        ex_ld_pending = 1'b1;
        ex_ld_rd      = 5'd5;
        io.if_valid   = 1'b1;
        io.if_instr   = 32'h0072_8333;
        io.if_pc      = 32'h200;
        #1;
        n_chk++;
        if (io.if_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL ldu_if_ready got %b want 0", io.if_ready);
        end
        tick();
        n_chk++;
        if (io.id_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL ldu_bubble got %b want 0", io.id_valid);
        end
        ex_ld_pending = 1'b0;
        #1;
        n_chk++;
        if (io.if_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ldu_release got %b want 1", io.if_ready);
        end
        tick();
        io.if_valid = 1'b0;
        n_chk++;
        if ({io.id_valid, io.id_rd, io.id_rs1_val, io.id_rs2_val}
            !== {1'b1, 5'd6, 32'h5555_0005, 32'h7777_0007}) begin
            n_fail++;
            $display("FAIL ldu_xfer got v=%b rd=%0d a=%h b=%h want 1 6 55550005 77770007",
                     io.id_valid, io.id_rd, io.id_rs1_val, io.id_rs2_val);
        end
    endtask

    task automatic test_bypass();
        idle();
        regs[3]     = 32'h0;
        wb_wr_en    = 1'b1;
        wb_addr     = 5'd3;
        wb_data     = 32'h1234;
        io.if_valid = 1'b1;
        io.if_instr = 32'h0011_8213;
        #1;
`ifdef ID_WB_BYPASS_EN
        n_chk++;
        if (io.if_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL byp_if_ready got %b want 1", io.if_ready);
        end
        tick();
        wb_wr_en = 1'b0;
`else
        n_chk++;
        if (io.if_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL wb_stall got %b want 0", io.if_ready);
        end
        tick();
        wb_wr_en = 1'b0;
        n_chk++;
        if (io.id_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL wb_bubble got %b want 0", io.id_valid);
        end
        tick();
`endif
        io.if_valid = 1'b0;
        n_chk++;
        if ({io.id_valid, io.id_rs1_val} !== {1'b1, 32'h1234}) begin
            n_fail++;
            $display("FAIL byp_val got v=%b rs1=%h want 1 1234",
                     io.id_valid, io.id_rs1_val);
        end
    endtask

    task automatic test_backpressure();
        logic [150:0] held;
        idle();
        io.if_valid = 1'b1;
        io.if_instr = 32'h0072_8333;
        io.if_pc    = 32'h300;
        held        = ref_pack(io.if_instr, io.if_pc);
        tick();
        io.id_ready = 1'b0;
        io.if_instr = 32'h0011_8213;
        io.if_pc    = 32'h304;
        for (int i = 0; i < 3; i++) begin
            flush = (i == 2);
            #1;
            n_chk++;
            if (io.if_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_if_ready[%0d] got %b want 0", i, io.if_ready);
            end
            n_chk++;
            if (io.id_valid !== 1'b1 || dut_pack() !== held) begin
                n_fail++;
                $display("FAIL bp_hold[%0d] got %b %h want 1 %h",
                         i, io.id_valid, dut_pack(), held);
            end
            tick();
        end
        flush       = 1'b0;
        io.if_valid = 1'b0;
        n_chk++;
        if (io.id_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_flush got %b want 0", io.id_valid);
        end
    endtask

    task automatic test_illegal();
        idle();
        io.if_valid = 1'b1;
        io.if_instr = 32'h0;
        tick();
        io.if_valid = 1'b0;
        n_chk++;
        if ({io.id_valid, io.id_illegal, io.id_imm} !== {1'b1, 1'b1, 32'h0}) begin
            n_fail++;
            $display("FAIL illegal got v=%b ill=%b imm=%h want 1 1 0",
                     io.id_valid, io.id_illegal, io.id_imm);
        end
    endtask

    task automatic test_async_reset();
        idle();
        regs[5]     = 32'hABCD_0001;
        io.if_valid = 1'b1;
        io.if_instr = 32'h0072_8333;
        tick();
        io.id_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        n_chk++;
        if ({io.id_valid, io.id_rs1_val} !== {1'b0, 32'h0}) begin
            n_fail++;
            $display("FAIL async_rst got v=%b rs1=%h want 0 0",
                     io.id_valid, io.id_rs1_val);
        end
        idle();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        n_chk++;
        if (io.id_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL post_rst got %b want 0", io.id_valid);
        end
    endtask

    task automatic test_random();
        logic [6:0]  ops [10];
        logic [6:0]  op;
        logic [31:0] r;
        bit          m_valid;
        logic [150:0] m_data;
        bit          exp_rdy;
        ops = '{7'h37, 7'h17, 7'h6f, 7'h67, 7'h63,
                7'h03, 7'h23, 7'h13, 7'h33, 7'h00};
        do_reset();
        m_valid = 1'b0;
        m_data  = '0;
        for (int c = 0; c < 600; c++) begin
            n_chk++;
            if (io.id_valid !== m_valid) begin
                n_fail++;
                $display("FAIL rnd_valid[%0d] got %b want %b", c, io.id_valid, m_valid);
            end
            if (m_valid) begin
                n_chk++;
                if (dut_pack() !== m_data) begin
                    n_fail++;
                    $display("FAIL rnd_data[%0d] got %h want %h", c, dut_pack(), m_data);
                end
            end
            op = ops[$urandom_range(9)];
            if (op == 7'h00) op = 7'($urandom);
            r = $urandom;
            io.if_instr   = {r[31:25], 2'b0, r[2:0], 2'b0, r[5:3],
                             r[14:12], r[11:7], op};
            io.if_valid   = ($urandom_range(3) != 0);
            io.if_pc      = $urandom;
            io.id_ready   = ($urandom_range(2) != 0);
            flush         = ($urandom_range(15) == 0);
            ex_ld_pending = ($urandom_range(2) == 0);
            ex_ld_rd      = 5'($urandom_range(7));
            wb_wr_en      = ($urandom_range(2) == 0);
            wb_addr       = 5'($urandom_range(7));
            wb_data       = $urandom;
            #1;
            exp_rdy = !ref_hazard(io.if_instr) && !flush
                   && (!m_valid || io.id_ready);
            n_chk++;
            if (io.if_ready !== exp_rdy) begin
                n_fail++;
                $display("FAIL rnd_if_ready[%0d] got %b want %b", c, io.if_ready, exp_rdy);
            end
            if (flush) begin
                m_valid = 1'b0;
            end else if (io.if_valid && exp_rdy) begin
                m_valid = 1'b1;
                m_data  = ref_pack(io.if_instr, io.if_pc);
            end else if (io.id_ready) begin
                m_valid = 1'b0;
            end
            tick();
        end
        idle();
    endtask

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = $urandom;
        test_reset();
        test_addi();
        test_load_use();
        test_bypass();
        test_backpressure();
        test_illegal();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired got timeout want finish");
        $fatal(1);
    end
endmodule
